// File: rtl/synth_pkg.sv
// Shared widths, synthesis filter coefficients and FSM encoding for the
// single-level wavelet reconstruction stage.
package synth_pkg;

  localparam int unsigned IN_W   = 16;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned ACC_W  = 28;
  localparam int unsigned PROD_W = IN_W + COEF_W;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned HIST   = 4;
  localparam int unsigned CNT_W  = 3;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [IN_W-1:0]   sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Synthesis low-pass (G0) and high-pass (G1) taps, index = 2*k + phase
  localparam coef_t G0 [TAPS] = '{-9'sd59, -9'sd183, -9'sd162, 9'sd7,
                                  9'sd48, -9'sd8, -9'sd8, 9'sd3};
  localparam coef_t G1 [TAPS] = '{-9'sd3, -9'sd8, 9'sd8, 9'sd48,
                                  -9'sd7, -9'sd162, 9'sd183, 9'sd59};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_E = 3'd1,
    OUT_E = 3'd2,
    MAC_O = 3'd3,
    OUT_O = 3'd4
  } state_t;

endpackage

// File: rtl/synth_mac.sv
// Registered 16x9 signed multiply-accumulate with synchronous clear and enable.
module synth_mac
  import synth_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    en,
  input  sample_t sample,
  input  coef_t   coef,
  output acc_t    acc
);

  logic signed [PROD_W-1:0] prod_c;

  assign prod_c = PROD_W'(sample) * PROD_W'(coef);

  // Full-scale sums stay below 2^27, so the accumulator never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/synth_recon.sv
// Wavelet synthesis stage: one (lo, hi) pair in, even then odd reconstructed
// sample out, computed on a single time-multiplexed MAC.
module synth_recon
  import synth_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   lo_in,
  input  logic signed [IN_W-1:0]   hi_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  data_out,
  output logic                     data_out_flag
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  sample_t          lo_h [HIST];
  sample_t          hi_h [HIST];

  acc_t             acc;
  logic             mac_clr;
  logic             mac_en;
  logic             phase;
  logic [2:0]       tap_idx;
  coef_t            coef_sel;
  sample_t          sample_sel;

  // Operand mux: cnt[2] selects band, cnt[1:0] selects history tap
  always_comb begin
    phase      = 1'b0;
    tap_idx    = '0;
    coef_sel   = '0;
    sample_sel = '0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    phase      = (state == MAC_O);
    tap_idx    = {cnt[1:0], phase};
    coef_sel   = cnt[2] ? G1[tap_idx] : G0[tap_idx];
    sample_sel = cnt[2] ? hi_h[cnt[1:0]] : lo_h[cnt[1:0]];
    mac_en     = (state == MAC_E) || (state == MAC_O);
    mac_clr    = ((state == IDLE) && in_valid) || (state == OUT_E);
  end

  synth_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .sample (sample_sel),
    .coef   (coef_sel),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      data_out      <= '0;
      data_out_flag <= 1'b0;
      cnt           <= '0;
      for (int i = 0; i < HIST; i++) begin
        lo_h[i] <= '0;
        hi_h[i] <= '0;
      end
    end else begin
      data_out_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = HIST - 1; i > 0; i--) begin
              lo_h[i] <= lo_h[i-1];
              hi_h[i] <= hi_h[i-1];
            end
            lo_h[0]  <= lo_in;
            hi_h[0]  <= hi_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MAC_E;
          end
        end
        MAC_E: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) state <= OUT_E;
        end
        OUT_E: begin
          data_out      <= acc;
          data_out_flag <= 1'b1;
          cnt           <= '0;
          state         <= MAC_O;
        end
        MAC_O: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) state <= OUT_O;
        end
        OUT_O: begin
          data_out      <= acc;
          data_out_flag <= 1'b1;
          in_ready      <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synth_recon.sv
// Scoreboard bench for synth_recon: a reference filter model queues expected
// samples per accepted pair; a negedge monitor pops them on each output flag.
module tb_synth_recon;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] lo_in = '0;
  logic signed [15:0] hi_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [27:0] data_out;
  logic               data_out_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic flag_d = 1'b0;

  logic signed [27:0] exp_q[$];
  int flag_cyc[$];

  int g0[8] = '{-59, -183, -162, 7, 48, -8, -8, 3};
  int g1[8] = '{-3, -8, 8, 48, -7, -162, 183, 59};
  int lo_m[4] = '{0, 0, 0, 0};
  int hi_m[4] = '{0, 0, 0, 0};

  synth_recon dut (
    .clk           (clk),
    .reset         (reset),
    .lo_in         (lo_in),
    .hi_in         (hi_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_out      (data_out),
    .data_out_flag (data_out_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_push(input int lo, input int hi);
    int y;
    for (int i = 3; i > 0; i--) begin
      lo_m[i] = lo_m[i-1];
      hi_m[i] = hi_m[i-1];
    end
    lo_m[0] = lo;
    hi_m[0] = hi;
    for (int p = 0; p < 2; p++) begin
      y = 0;
      for (int k = 0; k < 4; k++) y += g0[2*k+p] * lo_m[k] + g1[2*k+p] * hi_m[k];
      exp_q.push_back(28'(y));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      lo_m[i] = 0;
      hi_m[i] = 0;
    end
    exp_q.delete();
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge
  task automatic send_pair(input int lo, input int hi, input bit hold, output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", in_ready, 1);
    lo_in    = 16'(lo);
    hi_in    = 16'(hi);
    in_valid = 1'b1;
    model_push(lo, hi);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (flag_d) check("flag_width", data_out_flag, 0);
      if (data_out_flag) begin
        flag_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("spurious_flag", data_out_flag, 0);
        else check("data_out", data_out, exp_q.pop_front());
      end
    end
    flag_d = data_out_flag && reset;
  end

  initial begin
    int a0, a1, a2, tmp, busy_lo;
    #1 reset = 1'b0;
    #2;
    check("rst_data_out", data_out, 0);
    check("rst_flag", data_out_flag, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Low-band impulse
    send_pair(1, 0, 1'b0, tmp);
    repeat (4) send_pair(0, 0, 1'b0, tmp);
    drain();

    // High-band impulse
    send_pair(0, 1, 1'b0, tmp);
    repeat (4) send_pair(0, 0, 1'b0, tmp);
    drain();

    // Busy ignore: (5,5) offered throughout E1..E18 must not be taken
    send_pair(1, 0, 1'b1, a0);
    lo_in   = 16'sd5;
    hi_in   = 16'sd5;
    busy_lo = 0;
    for (int i = 0; i < 18; i++) begin
      if (!in_ready) busy_lo++;
      @(negedge clk);
    end
    check("busy_ready_low", busy_lo, 18);
    check("ready_after_e18", in_ready, 1);
    send_pair(0, 0, 1'b0, a1);
    check("busy_next_accept", a1 - a0, 19);
    repeat (3) send_pair(0, 0, 1'b0, tmp);
    drain();

    // Back-to-back with in_valid held high: acceptance spacing and flag timing
    flag_cyc.delete();
    send_pair(3, -2, 1'b1, a0);
    send_pair(-7, 4, 1'b1, a1);
    send_pair(100, -100, 1'b0, a2);
    drain();
    check("b2b_accept1", a1 - a0, 19);
    check("b2b_accept2", a2 - a0, 38);
    check("b2b_flag_count", flag_cyc.size(), 6);
    if (flag_cyc.size() == 6) begin
      check("flag_e9",  flag_cyc[0], a0 + 9);
      check("flag_e18", flag_cyc[1], a0 + 18);
      check("flag_e28", flag_cyc[2], a0 + 28);
      check("flag_e37", flag_cyc[3], a0 + 37);
      check("flag_e47", flag_cyc[4], a0 + 47);
      check("flag_e56", flag_cyc[5], a0 + 56);
    end

    // Full-scale stress on both bands
    repeat (5) send_pair(-32768, -32768, 1'b0, tmp);
    drain();

    // Reset mid-MAC at E5 aborts with outputs cleared
    send_pair(1, 0, 1'b0, a0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_flag", data_out_flag, 0);
    check("midrst_ready", in_ready, 1);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    send_pair(1, 0, 1'b0, tmp);
    repeat (4) send_pair(0, 0, 1'b0, tmp);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/synth_recon.md
# synth_recon

Single-level wavelet synthesis (reconstruction) stage: the inverse of the 8-tap analysis filter bank. It accepts one (low-band, high-band) coefficient pair per transaction, implicitly upsamples both bands by 2, filters them with the 8-tap synthesis pair and sums the results. Each accepted pair produces two reconstructed samples, even phase first. It sits downstream of coefficient storage/requantization, on the output side of the decomposition chain, and time-multiplexes one multiplier-accumulator.

## Interface
- No parameters. Widths and coefficients are fixed constants in the shared package.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- lo_in  in  16  signed low-band coefficient
- hi_in  in  16  signed high-band coefficient
- in_valid  in  1  pair present on lo_in/hi_in
- in_ready  out  1  block idle and able to accept a pair
- data_out  out  28  signed reconstructed sample, held until next update
- data_out_flag  out  1  one-cycle pulse, data_out newly valid

## Operation
- History registers:
  - lo_h[0..3] and hi_h[0..3], 16-bit signed.
  - On acceptance, lo_in shifts into lo_h[0] and lo_h[3] is discarded; hi likewise.
- Coefficients (two's complement, 9-bit signed):
  - G0 = -59, -183, -162, 7, 48, -8, -8, 3
  - G1 = -3, -8, 8, 48, -7, -162, 183, 59
- Phase p (0 = even, 1 = odd): y_p = Σk=0..3 G0[2k+p]·lo_h[k] + G1[2k+p]·hi_h[k].
- FSM states: IDLE, MAC_E, OUT_E, MAC_O, OUT_O.
- IDLE:
  - in_ready=1.
  - in_valid=1 triggers the history shift, acc←0, cnt←0, next state MAC_E.
- MAC_E / MAC_O: 8 cycles, cnt 0..7.
  - cnt 0..3: acc += G0[2·cnt+p]·lo_h[cnt]
  - cnt 4..7: acc += G1[2·(cnt−4)+p]·hi_h[cnt−4]
  - Leave the state at cnt==7.
- OUT_E: data_out←acc, data_out_flag←1, acc←0, cnt←0, next state MAC_O.
- OUT_O: data_out←acc, data_out_flag←1, next state IDLE.
- data_out_flag is 0 in every other cycle.
- Arithmetic:
  - 16×9 signed product is 25 bits, sign-extended to the 28-bit accumulator.
  - Worst case Σ|G|·32768 < 2^27, so the accumulator never overflows; no saturation or rounding.
- in_valid outside IDLE is ignored. No pair is captured, and the histories and the computation are unaffected.
- Reset value of every output and register:
  - state=IDLE, in_ready=1
  - data_out=0, data_out_flag=0
  - histories=0, acc=0, cnt=0
- Reset asserted mid-operation aborts immediately, with no flag pulse and history cleared.

## Timing
- Acceptance edge E0 (in_valid & in_ready sampled high).
- E1..E8: even-phase MAC; E9: even result registered, data_out_flag high for the cycle after E9.
- E10..E17: odd-phase MAC; E18: odd result registered, data_out_flag high for the cycle after E18.
- in_ready is high again after E18. The earliest next acceptance is E19, giving a throughput of one pair per 19 cycles.
- Latency from acceptance to even output is 9 cycles; to odd output, 18 cycles.
- Back-to-back: in_valid held high continuously produces acceptances at E0, E19, E38, …

## Structure
- Package synth_pkg holds:
  - widths: IN_W=16, COEF_W=9, ACC_W=28
  - G0/G1 coefficient constant arrays
  - the FSM state enum
- Sub-module synth_mac, one instance:
  - registered 16×9 signed multiply-accumulate with clear and enable
  - synth_recon supplies the operand mux, FSM and histories

## Test plan
- Low-band impulse: pairs (1,0) then (0,0)×4. data_out sequence is -59, -183, -162, 7, 48, -8, -8, 3, then zeros.
- High-band impulse: pairs (0,1) then (0,0)×4. data_out sequence is -3, -8, 8, 48, -7, -162, 183, 59, then zeros.
- Full-scale stress: lo=hi=-32768 for 5 pairs.
  - Even output of the 4th pair is -32768·(-59-162+48-8-3+8-7+183) = 32768·(-(-0))…
  - The bench computes it from the formula. The value must match exactly, with no wrap in 28 bits.
- Busy ignore: assert in_valid with pair (5,5) during cycles E1..E18.
  - Not captured; outputs are identical to the run without it.
  - in_ready=0 throughout; the next pair is accepted at E19.
- Reset mid-MAC: drop reset at E5 of the first pair.
  - data_out=0, flag=0, in_ready=1 immediately.
  - A following low-band impulse reproduces the clean impulse response.
- Flag timing: 3 back-to-back pairs with in_valid held high.
  - Flags occur one cycle after E9, E18, E28, E37, E47, E56.
  - Each flag is exactly one cycle wide.
